// File: rtl/axil_rr_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter: registered round-robin grant,
// one outstanding transaction, channels routed combinationally to the owner.
module axil_rr_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_M-1:0]           m_awvalid,
    input  logic [NUM_M-1:0]           m_arvalid,
    input  logic [NUM_M-1:0]           m_wvalid,
    input  logic [NUM_M-1:0]           m_bready,
    input  logic [NUM_M-1:0]           m_rready,
    input  logic [NUM_M*ADDR_W-1:0]    m_awaddr,
    input  logic [NUM_M*ADDR_W-1:0]    m_araddr,
    input  logic [NUM_M*DATA_W-1:0]    m_wdata,
    input  logic [NUM_M*STRB_W-1:0]    m_wstrb,
    output logic [NUM_M-1:0]           m_awready,
    output logic [NUM_M-1:0]           m_arready,
    output logic [NUM_M-1:0]           m_wready,
    output logic [NUM_M-1:0]           m_bvalid,
    output logic [NUM_M-1:0]           m_rvalid,
    output logic [NUM_M*2-1:0]         m_bresp,
    output logic [NUM_M*2-1:0]         m_rresp,
    output logic [NUM_M*DATA_W-1:0]    m_rdata,
    output logic                       s_awvalid,
    output logic [ADDR_W-1:0]          s_awaddr,
    output logic                       s_wvalid,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [STRB_W-1:0]          s_wstrb,
    output logic                       s_bready,
    output logic                       s_arvalid,
    output logic [ADDR_W-1:0]          s_araddr,
    output logic                       s_rready,
    input  logic                       s_awready,
    input  logic                       s_wready,
    input  logic                       s_bvalid,
    input  logic [1:0]                 s_bresp,
    input  logic                       s_arready,
    input  logic                       s_rvalid,
    input  logic [DATA_W-1:0]          s_rdata,
    input  logic [1:0]                 s_rresp
);

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] grant, grant_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0] grant_inc;
    logic             ar_done, ar_done_nxt;
    logic             aw_done, aw_done_nxt;
    logic             w_done, w_done_nxt;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] scan_idx;
    logic             found;

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            scan_idx = IDX_W'((32'(rr_ptr) + k) % NUM_M);
            if (!found && (m_arvalid[scan_idx] | m_awvalid[scan_idx])) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign grant_inc = (grant == IDX_W'(NUM_M - 1)) ? '0 : grant + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= '0;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_ptr  <= rr_ptr_nxt;
            ar_done <= ar_done_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    always_comb begin
        m_awready   = '0;
        m_arready   = '0;
        m_wready    = '0;
        m_bvalid    = '0;
        m_rvalid    = '0;
        m_bresp     = '0;
        m_rresp     = '0;
        m_rdata     = '0;
        s_awvalid   = 1'b0;
        s_awaddr    = '0;
        s_wvalid    = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_bready    = 1'b0;
        s_arvalid   = 1'b0;
        s_araddr    = '0;
        s_rready    = 1'b0;
        state_nxt   = state;
        grant_nxt   = grant;
        rr_ptr_nxt  = rr_ptr;
        ar_done_nxt = ar_done;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;

        case (state)
            IDLE: begin
                ar_done_nxt = 1'b0;
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
                // a master with both AR and AW pending is served read-first
                if (found) begin
                    grant_nxt = winner;
                    state_nxt = m_arvalid[winner] ? RD : WR;
                end
            end
            RD: begin
                s_arvalid                         = m_arvalid[grant] & ~ar_done;
                s_araddr                          = m_araddr[grant*ADDR_W +: ADDR_W];
                m_arready[grant]                  = s_arready & ~ar_done;
                s_rready                          = m_rready[grant];
                m_rvalid[grant]                   = s_rvalid;
                m_rdata[grant*DATA_W +: DATA_W]   = s_rdata;
                m_rresp[grant*2 +: 2]             = s_rresp;
                if (s_arvalid & s_arready) ar_done_nxt = 1'b1;
                if (s_rvalid & m_rready[grant]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = grant_inc;
                end
            end
            WR: begin
                s_awvalid             = m_awvalid[grant] & ~aw_done;
                s_awaddr              = m_awaddr[grant*ADDR_W +: ADDR_W];
                m_awready[grant]      = s_awready & ~aw_done;
                s_wvalid              = m_wvalid[grant] & ~w_done;
                s_wdata               = m_wdata[grant*DATA_W +: DATA_W];
                s_wstrb               = m_wstrb[grant*STRB_W +: STRB_W];
                m_wready[grant]       = s_wready & ~w_done;
                s_bready              = m_bready[grant];
                m_bvalid[grant]       = s_bvalid;
                m_bresp[grant*2 +: 2] = s_bresp;
                if (s_awvalid & s_awready) aw_done_nxt = 1'b1;
                if (s_wvalid & s_wready)   w_done_nxt  = 1'b1;
                if (s_bvalid & m_bready[grant]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = grant_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Bench for axil_rr_arbiter (3 masters): ownership/round-robin reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_axil_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]    m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready;
    logic [N*AW-1:0] m_awaddr, m_araddr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N-1:0]    m_awready, m_arready, m_wready, m_bvalid, m_rvalid;
    logic [N*2-1:0]  m_bresp, m_rresp;
    logic [N*DW-1:0] m_rdata;
    logic            s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [AW-1:0]   s_awaddr, s_araddr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]      s_bresp, s_rresp;
    logic [DW-1:0]   s_rdata;

    axil_rr_arbiter #(.NUM_M(N), .ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
        .clk(clk), .rst(rst),
        .m_awvalid(m_awvalid), .m_arvalid(m_arvalid), .m_wvalid(m_wvalid),
        .m_bready(m_bready), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_araddr(m_araddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_awready(m_awready), .m_arready(m_arready), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_rvalid(m_rvalid),
        .m_bresp(m_bresp), .m_rresp(m_rresp), .m_rdata(m_rdata),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_wvalid(s_wvalid),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_rready(s_rready),
        .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: who owns the slave, which phases are finished, and the
    // round-robin start point. -1 means nobody owns the slave.
    int  own = -1, n_own = -1;
    int  ptr = 0,  n_ptr = 0;
    bit  own_rd = 0, n_rd = 0;
    bit  a_done = 0, n_a = 0;
    bit  w_done = 0, n_w = 0;
    bit  chk_en = 0;

    logic [N-1:0]    e_awready, e_arready, e_wready, e_bvalid, e_rvalid;
    logic [N*2-1:0]  e_bresp, e_rresp;
    logic [N*DW-1:0] e_rdata;
    logic            e_awvalid, e_wvalid, e_bready, e_arvalid, e_rready;
    logic [AW-1:0]   e_awaddr, e_araddr;
    logic [DW-1:0]   e_wdata;
    logic [SW-1:0]   e_wstrb;
    logic [N-1:0]    hs_ar, hs_r, hs_aw, hs_w, hs_b;
    bit              hs_s_ar, hs_s_r, hs_s_aw, hs_s_w, hs_s_b;

    always @(negedge clk) begin
        if (chk_en) begin
            e_awready = '0; e_arready = '0; e_wready = '0; e_bvalid = '0; e_rvalid = '0;
            e_bresp = '0; e_rresp = '0; e_rdata = '0;
            e_awvalid = 0; e_wvalid = 0; e_bready = 0; e_arvalid = 0; e_rready = 0;
            e_awaddr = '0; e_araddr = '0; e_wdata = '0; e_wstrb = '0;
            if (own >= 0 && own_rd) begin
                e_arvalid           = m_arvalid[own] && !a_done;
                e_araddr            = m_araddr[own*AW +: AW];
                e_arready[own]      = s_arready && !a_done;
                e_rready            = m_rready[own];
                e_rvalid[own]       = s_rvalid;
                e_rdata[own*DW +: DW] = s_rdata;
                e_rresp[own*2 +: 2] = s_rresp;
            end else if (own >= 0) begin
                e_awvalid           = m_awvalid[own] && !a_done;
                e_awaddr            = m_awaddr[own*AW +: AW];
                e_awready[own]      = s_awready && !a_done;
                e_wvalid            = m_wvalid[own] && !w_done;
                e_wdata             = m_wdata[own*DW +: DW];
                e_wstrb             = m_wstrb[own*SW +: SW];
                e_wready[own]       = s_wready && !w_done;
                e_bready            = m_bready[own];
                e_bvalid[own]       = s_bvalid;
                e_bresp[own*2 +: 2] = s_bresp;
            end
            chk("m_awready", m_awready, e_awready);
            chk("m_arready", m_arready, e_arready);
            chk("m_wready",  m_wready,  e_wready);
            chk("m_bvalid",  m_bvalid,  e_bvalid);
            chk("m_rvalid",  m_rvalid,  e_rvalid);
            chk("m_bresp",   m_bresp,   e_bresp);
            chk("m_rresp",   m_rresp,   e_rresp);
            chk("m_rdata",   m_rdata,   e_rdata);
            chk("s_awvalid", s_awvalid, e_awvalid);
            chk("s_awaddr",  s_awaddr,  e_awaddr);
            chk("s_wvalid",  s_wvalid,  e_wvalid);
            chk("s_wdata",   s_wdata,   e_wdata);
            chk("s_wstrb",   s_wstrb,   e_wstrb);
            chk("s_bready",  s_bready,  e_bready);
            chk("s_arvalid", s_arvalid, e_arvalid);
            chk("s_araddr",  s_araddr,  e_araddr);
            chk("s_rready",  s_rready,  e_rready);

            hs_ar = e_arready & m_arvalid;
            hs_r  = e_rvalid  & m_rready;
            hs_aw = e_awready & m_awvalid;
            hs_w  = e_wready  & m_wvalid;
            hs_b  = e_bvalid  & m_bready;
            hs_s_ar = e_arvalid && s_arready;
            hs_s_r  = s_rvalid && e_rready;
            hs_s_aw = e_awvalid && s_awready;
            hs_s_w  = e_wvalid && s_wready;
            hs_s_b  = s_bvalid && e_bready;

            n_own = own; n_ptr = ptr; n_rd = own_rd; n_a = a_done; n_w = w_done;
            if (rst) begin
                n_own = -1; n_ptr = 0; n_a = 0; n_w = 0;
            end else if (own < 0) begin
                n_a = 0; n_w = 0;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (ptr + k) % N;
                    if (n_own < 0 && (m_arvalid[idx] || m_awvalid[idx])) begin
                        n_own = idx;
                        n_rd  = m_arvalid[idx];
                    end
                end
            end else if (own_rd) begin
                if (hs_s_ar) n_a = 1;
                if (hs_s_r) begin n_own = -1; n_ptr = (own + 1) % N; end
            end else begin
                if (hs_s_aw) n_a = 1;
                if (hs_s_w)  n_w = 1;
                if (hs_s_b) begin n_own = -1; n_ptr = (own + 1) % N; end
            end
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            own <= n_own; ptr <= n_ptr; own_rd <= n_rd; a_done <= n_a; w_done <= n_w;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_awvalid = '0; m_arvalid = '0; m_wvalid = '0; m_bready = '0; m_rready = '0;
        m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_wstrb = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
    endtask

    // random-traffic agents
    bit [N-1:0] ar_on, aw_on, w_on, rd_wait, wr_busy;
    bit s_rd_pend, r_act, aw_got, w_got, b_act;

    task automatic rand_cycle();
        for (int i = 0; i < N; i++) begin
            if (hs_ar[i]) begin ar_on[i] = 0; rd_wait[i] = 1; end
            if (hs_r[i])  rd_wait[i] = 0;
            if (hs_aw[i]) aw_on[i] = 0;
            if (hs_w[i])  w_on[i] = 0;
            if (hs_b[i])  wr_busy[i] = 0;
            if (!ar_on[i] && !rd_wait[i] && $urandom_range(3) == 0) begin
                ar_on[i] = 1;
                m_araddr[i*AW +: AW] = $urandom;
            end
            if (!wr_busy[i] && $urandom_range(3) == 0) begin
                wr_busy[i] = 1; aw_on[i] = 1; w_on[i] = 1;
                m_awaddr[i*AW +: AW] = $urandom;
                m_wdata[i*DW +: DW]  = $urandom;
                m_wstrb[i*SW +: SW]  = SW'($urandom);
            end
            m_arvalid[i] = ar_on[i];
            m_awvalid[i] = aw_on[i];
            m_wvalid[i]  = w_on[i];
            m_rready[i]  = 1'($urandom_range(1));
            m_bready[i]  = 1'($urandom_range(1));
        end
        if (hs_s_ar) s_rd_pend = 1;
        if (hs_s_r)  begin s_rd_pend = 0; r_act = 0; end
        if (hs_s_aw) aw_got = 1;
        if (hs_s_w)  w_got = 1;
        if (hs_s_b)  begin aw_got = 0; w_got = 0; b_act = 0; end
        s_arready = 1'($urandom_range(1));
        s_awready = 1'($urandom_range(1));
        s_wready  = 1'($urandom_range(1));
        if (!r_act && s_rd_pend && $urandom_range(1) == 1) begin
            r_act = 1; s_rdata = $urandom; s_rresp = 2'($urandom);
        end
        if (!b_act && aw_got && w_got && $urandom_range(1) == 1) begin
            b_act = 1; s_bresp = 2'($urandom);
        end
        // unsolicited responses while the other channel type owns the slave
        s_rvalid = r_act;
        if (!r_act && own >= 0 && !own_rd && $urandom_range(3) == 0) begin
            s_rvalid = 1; s_rdata = $urandom;
        end
        s_bvalid = b_act;
        if (!b_act && own >= 0 && own_rd && $urandom_range(3) == 0) begin
            s_bvalid = 1; s_bresp = 2'($urandom);
        end
    endtask

    int got[$];
    int exp_order[5] = '{0, 1, 2, 0, 1};

    initial begin
        clear_inputs();
        rst = 1;
        tick();
        chk_en = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("reset_m_out", {m_awready, m_arready, m_wready, m_bvalid, m_rvalid, m_bresp, m_rresp}, '0);
        chk("reset_s_valid", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, '0);

        // master 0 read, with an unsolicited B while the read is active
        tick();
        m_arvalid = 3'b001; m_araddr[31:0] = 32'h8000_0000;
        @(negedge clk);
        chk("rd_arb_cycle", s_arvalid, 1'b0);
        tick();
        s_arready = 1; s_bvalid = 1;
        @(negedge clk);
        chk("rd_s_arvalid", s_arvalid, 1'b1);
        chk("rd_s_araddr", s_araddr, 32'h8000_0000);
        chk("rd_m_arready", m_arready, 3'b001);
        chk("rd_spur_bready", s_bready, 1'b0);
        tick();
        m_arvalid = '0; s_arready = 0;
        s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'd0; m_rready = 3'b001;
        @(negedge clk);
        chk("rd_m_rvalid", m_rvalid, 3'b001);
        chk("rd_m_rdata", m_rdata, {64'h0, 32'hDEAD_BEEF});
        chk("rd_s_arvalid_done", s_arvalid, 1'b0);
        chk("rd_spur_m_bvalid", m_bvalid, 3'b000);
        tick();
        clear_inputs();

        // pointer now at 1: masters 0 and 2 compete, 2 is next in order
        m_arvalid = 3'b101; m_araddr = {32'h300, 32'h0, 32'h100};
        tick();
        @(negedge clk);
        chk("rrptr1_winner", s_araddr, 32'h300);
        rst = 1; m_arvalid = '0;
        tick();
        rst = 0;

        // all three hold AR: grants must rotate 0,1,2,0,1
        m_arvalid = 3'b111; m_araddr = {32'h1020, 32'h1010, 32'h1000};
        s_arready = 1; s_rvalid = 1; m_rready = 3'b111;
        for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
            @(negedge clk);
            if (s_arvalid) got.push_back(int'((s_araddr - 32'h1000) >> 4));
            tick();
        end
        clear_inputs();
        chk("rr_count", 128'(got.size()), 128'd5);
        for (int k = 0; k < 5 && k < got.size(); k++)
            chk("rr_order", 128'(got[k]), 128'(exp_order[k]));

        // master 1 write, W accepted two cycles before AW
        m_awvalid = 3'b010; m_wvalid = 3'b010; m_bready = 3'b010;
        m_awaddr[63:32] = 32'h8000_0010; m_wdata[63:32] = 32'h1234_5678; m_wstrb[7:4] = 4'hF;
        s_wready = 1;
        @(negedge clk);
        chk("wr_arb_cycle", s_wvalid, 1'b0);
        tick();
        @(negedge clk);
        chk("wr_s_wvalid", s_wvalid, 1'b1);
        chk("wr_s_wdata", {s_wstrb, s_wdata}, {4'hF, 32'h1234_5678});
        chk("wr_m_wready", m_wready, 3'b010);
        tick();
        @(negedge clk);
        chk("wr_w_done", {s_wvalid, m_wready}, 4'b0000);
        tick();
        s_awready = 1;
        @(negedge clk);
        chk("wr_aw", {s_awvalid, s_awaddr, m_awready}, {1'b1, 32'h8000_0010, 3'b010});
        tick();
        s_awready = 0; s_bvalid = 1; s_bresp = 2'd0;
        @(negedge clk);
        chk("wr_b", {m_bvalid, m_bresp, s_bready, s_awvalid}, {3'b010, 6'd0, 1'b1, 1'b0});
        tick();
        clear_inputs();

        // master 0 with AR and AW together: read first, then write
        m_arvalid = 3'b001; m_awvalid = 3'b001; m_wvalid = 3'b001;
        m_araddr[31:0] = 32'h40; m_awaddr[31:0] = 32'h44;
        tick();
        s_arready = 1; s_rvalid = 1; m_rready = 3'b001;
        @(negedge clk);
        chk("both_read_first", {s_arvalid, s_awvalid}, 2'b10);
        tick();
        m_arvalid = '0; s_arready = 0; s_rvalid = 0; m_rready = '0;
        tick();
        s_awready = 1;
        @(negedge clk);
        chk("both_write_after", {s_awvalid, s_wvalid, s_arvalid}, 3'b110);
        tick();
        s_awready = 0;
        @(negedge clk);
        chk("mid_wr_aw_done", s_awvalid, 1'b0);

        // reset with AW done and B outstanding
        rst = 1;
        tick();
        rst = 0; clear_inputs();
        @(negedge clk);
        chk("rst_mid_outs", {m_awready, m_arready, m_wready, m_bvalid, m_rvalid, m_bresp, m_rresp,
                             s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, '0);
        chk("rst_mid_data", {s_awaddr, s_araddr, s_wdata, m_rdata}, '0);
        m_arvalid = 3'b101; m_araddr = {32'h300, 32'h0, 32'h100};
        tick();
        @(negedge clk);
        chk("rst_ptr0_winner", s_araddr, 32'h100);
        rst = 1;
        tick();
        rst = 0; clear_inputs();
        m_arvalid = 3'b010; m_araddr[63:32] = 32'h8000_0020;
        tick();
        @(negedge clk);
        chk("rst_fresh_m1", {s_arvalid, s_araddr}, {1'b1, 32'h8000_0020});

        // random traffic
        rst = 1;
        tick();
        tick();
        rst = 0;
        clear_inputs();
        ar_on = '0; aw_on = '0; w_on = '0; rd_wait = '0; wr_busy = '0;
        s_rd_pend = 0; r_act = 0; aw_got = 0; w_got = 0; b_act = 0;
        hs_ar = '0; hs_r = '0; hs_aw = '0; hs_w = '0; hs_b = '0;
        hs_s_ar = 0; hs_s_r = 0; hs_s_aw = 0; hs_s_w = 0; hs_s_b = 0;
        for (int c = 0; c < 3000; c++) begin
            rand_cycle();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
